usb_rx_packet_buffer: RTL and testbench

Receive-side packet buffer between `usb_rx` and the endpoint/protocol logic, all in the `clk48` domain. Consumes the `usb_rx` byte handshake (`rxDataValid`/`rxAcceptNewData`/`rxIsLastByte`/`keepPacket`) and stores bytes tentatively in a circular buffer. On the last byte it commits the packet if `keepPacket` is set and no overflow occurred; otherwise it rolls the packet back. Committed packets are presented downstream as a valid/ready byte stream with a per-byte last flag.

---
 rtl/sie_defs_pkg.sv | 23 ++
 rtl/usb_rx_packet_buffer_mem.sv | 38 +++
 rtl/usb_rx_packet_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_usb_rx_packet_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sie_defs_pkg.sv
// -----------------------------------------------------------------------------
// sie_defs_pkg
// Shared definitions for the serial interface engine receive path.
//   RX_BUF_DEPTH_LOG2 : default log2 depth of the receive packet buffer
//   RxBufState        : receive packet buffer control states
//   RxBufWord         : one stored buffer entry {isLast, data}
// -----------------------------------------------------------------------------
package sie_defs_pkg;

  localparam int RX_BUF_DEPTH_LOG2 = 7;

  typedef enum logic [1:0] {
    BUF_IDLE    = 2'd0,
    BUF_RECEIVE = 2'd1,
    BUF_DISCARD = 2'd2
  } RxBufState;

  typedef struct packed {
    logic       isLast;
    logic [7:0] data;
  } RxBufWord;

endpackage

// File: rtl/usb_rx_packet_buffer_mem.sv
// -----------------------------------------------------------------------------
// rx_buf_mem
// Storage array for the receive packet buffer: synchronous write,
// asynchronous (combinational) read. Contents are deliberately not reset.
// Ports:
//   clk48   : clock
//   wrEn    : write enable
//   wrAddr  : write address
//   wrData  : write data
//   rdAddr  : read address
//   rdData  : read data, combinational from rdAddr
// -----------------------------------------------------------------------------
module rx_buf_mem #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 9
) (
  input  logic              clk48,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Array write port.
  always_ff @(posedge clk48) begin
    if (wrEn) begin
      mem_r[wrAddr] <= wrData;
    end
  end

  assign rdData = mem_r[rdAddr];

endmodule

// File: rtl/usb_rx_packet_buffer.sv
// -----------------------------------------------------------------------------
// usb_rx_packet_buffer
// Receive-side packet buffer between usb_rx and the endpoint logic. Bytes are
// written tentatively; a packet becomes visible to the reader only when its
// last byte arrives with keepPacket set and without overflow. Otherwise the
// write pointer is rolled back to the last commit point.
// Ports:
//   clk48           : clock
//   RST_N           : asynchronous active-low reset
//   rxAcceptNewData : ready towards usb_rx (1 from first edge after reset)
//   rxDataValid     : byte valid from usb_rx
//   rxData          : byte from usb_rx
//   rxIsLastByte    : current byte ends the packet
//   keepPacket      : packet integrity flag, sampled on last-byte handshake
//   rdData          : byte at read pointer
//   rdIsLast        : rdData ends its packet
//   rdValid         : a committed byte is available
//   rdReady         : consumer accepts rdData
//   pktCount        : committed packets not yet fully read
//   pktDropped      : one-cycle pulse when a packet is rolled back
//   dropCount       : saturating count of dropped packets
// -----------------------------------------------------------------------------
module usb_rx_packet_buffer
  import sie_defs_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_BUF_DEPTH_LOG2,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk48,
  input  logic                  RST_N,
  output logic                  rxAcceptNewData,
  input  logic                  rxDataValid,
  input  logic [7:0]            rxData,
  input  logic                  rxIsLastByte,
  input  logic                  keepPacket,
  output logic [7:0]            rdData,
  output logic                  rdIsLast,
  output logic                  rdValid,
  input  logic                  rdReady,
  output logic [DEPTH_LOG2:0]   pktCount,
  output logic                  pktDropped,
  output logic [DROP_CNT_W-1:0] dropCount
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0]      PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]      DEPTH_VAL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = {DROP_CNT_W{1'b1}};
  localparam logic [DROP_CNT_W-1:0] DROP_ONE  = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

  RxBufState             state_r;
  RxBufState             nextState_s;
  logic [PTR_W-1:0]      wrPtr_r;
  logic [PTR_W-1:0]      commitPtr_r;
  logic [PTR_W-1:0]      rdPtr_r;
  logic [PTR_W-1:0]      wrPtrNext_s;
  logic [PTR_W-1:0]      commitPtrNext_s;
  logic [DEPTH_LOG2:0]   pktCount_r;
  logic [DROP_CNT_W-1:0] dropCount_r;
  logic                  pktDropped_r;
  logic                  rxAccept_r;

  logic     wrHs_s;
  logic     rdHs_s;
  logic     rdLast_s;
  logic     full_s;
  logic     memWe_s;
  logic     commit_s;
  logic     drop_s;
  RxBufWord wrWord_s;
  RxBufWord rdWord_s;

  // Full is judged on pre-update pointers: a same-cycle read frees nothing.
  assign full_s   = ((wrPtr_r - rdPtr_r) == DEPTH_VAL);
  assign wrHs_s   = rxDataValid && rxAccept_r;
  assign rdValid  = (rdPtr_r != commitPtr_r);
  assign rdHs_s   = rdValid && rdReady;
  assign rdLast_s = rdHs_s && rdWord_s.isLast;
  assign wrWord_s = {rxIsLastByte, rxData};

  rx_buf_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (9)
  ) uMem (
    .clk48  (clk48),
    .wrEn   (memWe_s),
    .wrAddr (wrPtr_r[DEPTH_LOG2-1:0]),
    .wrData (wrWord_s),
    .rdAddr (rdPtr_r[DEPTH_LOG2-1:0]),
    .rdData (rdWord_s)
  );

  // Next-state, tentative write and commit/rollback decision.
  always_comb begin
    nextState_s     = state_r;
    memWe_s         = 1'b0;
    wrPtrNext_s     = wrPtr_r;
    commitPtrNext_s = commitPtr_r;
    commit_s        = 1'b0;
    drop_s          = 1'b0;

    case (state_r)
      BUF_IDLE, BUF_RECEIVE: begin
        if (wrHs_s) begin
          if (!full_s) begin
            memWe_s     = 1'b1;
            wrPtrNext_s = wrPtr_r + PTR_ONE;
            nextState_s = BUF_RECEIVE;
          end else begin
            nextState_s = BUF_DISCARD;
          end
        end else begin
          nextState_s = state_r;
        end
      end
      BUF_DISCARD: begin
        nextState_s = BUF_DISCARD;
      end
      default: begin
        nextState_s = BUF_IDLE;
      end
    endcase

    // The last byte closes the packet from any state; this overrides the
    // per-state decisions above, including a single-byte packet from idle.
    if (wrHs_s && rxIsLastByte) begin
      if (keepPacket && (state_r != BUF_DISCARD) && !full_s) begin
        commit_s        = 1'b1;
        commitPtrNext_s = wrPtr_r + PTR_ONE;
      end else begin
        drop_s      = 1'b1;
        wrPtrNext_s = commitPtr_r;
      end
      nextState_s = BUF_IDLE;
    end else begin
      commit_s = 1'b0;
      drop_s   = 1'b0;
    end
  end

  // State and write-side pointers.
  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= BUF_IDLE;
      wrPtr_r     <= {PTR_W{1'b0}};
      commitPtr_r <= {PTR_W{1'b0}};
    end else begin
      state_r     <= nextState_s;
      wrPtr_r     <= wrPtrNext_s;
      commitPtr_r <= commitPtrNext_s;
    end
  end

  // Read pointer advances on every read handshake.
  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N) begin
      rdPtr_r <= {PTR_W{1'b0}};
    end else if (rdHs_s) begin
      rdPtr_r <= rdPtr_r + PTR_ONE;
    end else begin
      rdPtr_r <= rdPtr_r;
    end
  end

  // Committed-packet count; a commit and a last-byte read cancel out.
  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N) begin
      pktCount_r <= {PTR_W{1'b0}};
    end else if (commit_s && !rdLast_s) begin
      pktCount_r <= pktCount_r + PTR_ONE;
    end else if (!commit_s && rdLast_s) begin
      pktCount_r <= pktCount_r - PTR_ONE;
    end else begin
      pktCount_r <= pktCount_r;
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N) begin
      pktDropped_r <= 1'b0;
      dropCount_r  <= {DROP_CNT_W{1'b0}};
    end else begin
      pktDropped_r <= drop_s;
      if (drop_s && (dropCount_r != DROP_MAX)) begin
        dropCount_r <= dropCount_r + DROP_ONE;
      end else begin
        dropCount_r <= dropCount_r;
      end
    end
  end

  // Ready towards usb_rx: low only in reset, since bytes are always consumed.
  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N) begin
      rxAccept_r <= 1'b0;
    end else begin
      rxAccept_r <= 1'b1;
    end
  end

  assign rxAcceptNewData = rxAccept_r;
  assign rdData          = rdWord_s.data;
  assign rdIsLast        = rdWord_s.isLast;
  assign pktCount        = pktCount_r;
  assign pktDropped      = pktDropped_r;
  assign dropCount       = dropCount_r;

endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_packet_buffer
// Self-checking bench for usb_rx_packet_buffer (DEPTH_LOG2=4). A table of
// per-cycle vectors covers basic commit, rollback, single-byte packets and
// simultaneous commit/last-read; hand-written sequences cover overflow,
// exact fill, back-to-back traffic, pointer wrap, saturation and reset.
// -----------------------------------------------------------------------------
module tb_usb_rx_packet_buffer;

  localparam int DL2 = 4;
  localparam int DCW = 8;

  logic           clk48 = 1'b0;
  logic           RST_N;
  logic           rxAcceptNewData;
  logic           rxDataValid;
  logic [7:0]     rxData;
  logic           rxIsLastByte;
  logic           keepPacket;
  logic [7:0]     rdData;
  logic           rdIsLast;
  logic           rdValid;
  logic           rdReady;
  logic [DL2:0]   pktCount;
  logic           pktDropped;
  logic [DCW-1:0] dropCount;

  int checks   = 0;
  int failures = 0;

  usb_rx_packet_buffer #(
    .DEPTH_LOG2 (DL2),
    .DROP_CNT_W (DCW)
  ) dut (
    .clk48           (clk48),
    .RST_N           (RST_N),
    .rxAcceptNewData (rxAcceptNewData),
    .rxDataValid     (rxDataValid),
    .rxData          (rxData),
    .rxIsLastByte    (rxIsLastByte),
    .keepPacket      (keepPacket),
    .rdData          (rdData),
    .rdIsLast        (rdIsLast),
    .rdValid         (rdValid),
    .rdReady         (rdReady),
    .pktCount        (pktCount),
    .pktDropped      (pktDropped),
    .dropCount       (dropCount)
  );

  // Free-running 10-unit clock.
  always #5 clk48 = ~clk48;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       k;
    logic       rr;
    logic       eValid;
    logic [7:0] eData;
    logic       eLast;
    logic [4:0] ePkt;
    logic       eDropped;
    logic [7:0] eDropCnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic last, input logic keep);
    rxDataValid  = 1'b1;
    rxData       = d;
    rxIsLastByte = last;
    keepPacket   = keep;
    tick();
    rxDataValid  = 1'b0;
    rxIsLastByte = 1'b0;
    keepPacket   = 1'b0;
  endtask

  task automatic expectByte(input logic [7:0] d, input logic last, input string name);
    bit got = 1'b0;
    rdReady = 1'b1;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk48);
      if (rdValid === 1'b1) begin
        chk({name, "_data"}, {24'd0, rdData}, {24'd0, d});
        chk({name, "_last"}, {31'd0, rdIsLast}, {31'd0, last});
        got = 1'b1;
        tick();
        break;
      end
      tick();
    end
    rdReady = 1'b0;
    if (!got) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] inB [10];
    logic       inL [10];
    logic       inK [10];
    logic [7:0] expB [7];
    logic       expL [7];
    logic [7:0] gotB [16];
    logic       gotL [16];
    int         nGot;
    logic [7:0] b;

    vecs[0]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 5'd1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 5'd1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd1};
    vecs[13] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 5'd1, 1'b0, 8'd1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd1};
    vecs[16] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd1};
    vecs[17] = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 5'd1, 1'b0, 8'd1};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 5'd1, 1'b0, 8'd1};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'd1};

    // ---------------- reset ----------------
    RST_N        = 1'b0;
    rxDataValid  = 1'b0;
    rxData       = 8'h00;
    rxIsLastByte = 1'b0;
    keepPacket   = 1'b0;
    rdReady      = 1'b0;
    #12;
    chk("rst_accept",   {31'd0, rxAcceptNewData}, 32'd0);
    chk("rst_rdvalid",  {31'd0, rdValid}, 32'd0);
    chk("rst_pktcount", {27'd0, pktCount}, 32'd0);
    chk("rst_dropped",  {31'd0, pktDropped}, 32'd0);
    chk("rst_dropcnt",  {24'd0, dropCount}, 32'd0);
    RST_N = 1'b1;
    tick();
    chk("accept_after_reset", {31'd0, rxAcceptNewData}, 32'd1);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 20; i++) begin
      rxDataValid  = vecs[i].v;
      rxData       = vecs[i].d;
      rxIsLastByte = vecs[i].l;
      keepPacket   = vecs[i].k;
      rdReady      = vecs[i].rr;
      @(negedge clk48);
      chk($sformatf("vec%0d_rdvalid", i), {31'd0, rdValid}, {31'd0, vecs[i].eValid});
      if (vecs[i].eValid) begin
        chk($sformatf("vec%0d_rddata", i), {24'd0, rdData}, {24'd0, vecs[i].eData});
        chk($sformatf("vec%0d_rdlast", i), {31'd0, rdIsLast}, {31'd0, vecs[i].eLast});
      end
      chk($sformatf("vec%0d_pktcount", i), {27'd0, pktCount}, {27'd0, vecs[i].ePkt});
      chk($sformatf("vec%0d_dropped", i), {31'd0, pktDropped}, {31'd0, vecs[i].eDropped});
      chk($sformatf("vec%0d_dropcnt", i), {24'd0, dropCount}, {24'd0, vecs[i].eDropCnt});
      tick();
    end
    rxDataValid  = 1'b0;
    rxIsLastByte = 1'b0;
    keepPacket   = 1'b0;
    rdReady      = 1'b0;

    // ---------------- overflow: 20-byte packet into 16 entries ----------------
    for (int i = 1; i <= 20; i++) begin
      b = 8'h30 + 8'(i);
      sendByte(b, (i == 20), 1'b1);
      chk("ovf_accept", {31'd0, rxAcceptNewData}, 32'd1);
    end
    chk("ovf_dropped", {31'd0, pktDropped}, 32'd1);
    chk("ovf_dropcnt", {24'd0, dropCount}, 32'd2);
    chk("ovf_rdvalid", {31'd0, rdValid}, 32'd0);
    tick();
    chk("ovf_dropped_pulse", {31'd0, pktDropped}, 32'd0);
    sendByte(8'hE1, 1'b0, 1'b1);
    sendByte(8'hE2, 1'b1, 1'b1);
    chk("ovf_next_pktcount", {27'd0, pktCount}, 32'd1);
    expectByte(8'hE1, 1'b0, "ovf_next0");
    expectByte(8'hE2, 1'b1, "ovf_next1");
    chk("ovf_next_empty", {31'd0, rdValid}, 32'd0);
    chk("ovf_next_pktcount0", {27'd0, pktCount}, 32'd0);

    // ---------------- exact fill, then packet into a full buffer ----------------
    for (int i = 0; i < 16; i++) begin
      b = 8'h40 + 8'(i);
      sendByte(b, (i == 15), 1'b1);
    end
    chk("fill_pktcount", {27'd0, pktCount}, 32'd1);
    chk("fill_dropped", {31'd0, pktDropped}, 32'd0);
    sendByte(8'h99, 1'b1, 1'b1);
    chk("full_dropped", {31'd0, pktDropped}, 32'd1);
    chk("full_dropcnt", {24'd0, dropCount}, 32'd3);
    chk("full_pktcount", {27'd0, pktCount}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      b = 8'h40 + 8'(i);
      expectByte(b, (i == 15), $sformatf("fill_rd%0d", i));
    end
    chk("fill_empty", {31'd0, rdValid}, 32'd0);
    chk("fill_pktcount0", {27'd0, pktCount}, 32'd0);

    // ---------------- back-to-back with toggling rdReady ----------------
    for (int i = 0; i < 5; i++) begin
      inB[i] = 8'hB0 + 8'(i); inL[i] = (i == 4); inK[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      inB[5+i] = 8'hC0 + 8'(i); inL[5+i] = (i == 2); inK[5+i] = 1'b0;
    end
    inB[8] = 8'hD0; inL[8] = 1'b0; inK[8] = 1'b1;
    inB[9] = 8'hD1; inL[9] = 1'b1; inK[9] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expB[i] = 8'hB0 + 8'(i); expL[i] = (i == 4);
    end
    expB[5] = 8'hD0; expL[5] = 1'b0;
    expB[6] = 8'hD1; expL[6] = 1'b1;
    nGot = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 10) begin
        rxDataValid  = 1'b1;
        rxData       = inB[c];
        rxIsLastByte = inL[c];
        keepPacket   = inK[c];
      end else begin
        rxDataValid  = 1'b0;
        rxIsLastByte = 1'b0;
        keepPacket   = 1'b0;
      end
      rdReady = ((c % 2) == 1);
      @(negedge clk48);
      if (rdValid && rdReady) begin
        if (nGot < 16) begin
          gotB[nGot] = rdData;
          gotL[nGot] = rdIsLast;
        end
        nGot++;
      end
      chk("b2b_pktcount_bound", {31'd0, (pktCount <= 5'd3)}, 32'd1);
      tick();
    end
    rxDataValid = 1'b0;
    rdReady     = 1'b0;
    chk("b2b_count", nGot, 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < nGot) begin
        chk($sformatf("b2b_data%0d", i), {24'd0, gotB[i]}, {24'd0, expB[i]});
        chk($sformatf("b2b_last%0d", i), {31'd0, gotL[i]}, {31'd0, expL[i]});
      end
    end
    chk("b2b_pktcount0", {27'd0, pktCount}, 32'd0);
    chk("b2b_dropcnt", {24'd0, dropCount}, 32'd4);

    // ---------------- pointer wrap: 40 packets of 6 bytes ----------------
    for (int p = 0; p < 40; p++) begin
      for (int j = 0; j < 6; j++) begin
        b = 8'(p * 7 + j);
        sendByte(b, (j == 5), 1'b1);
      end
      for (int j = 0; j < 6; j++) begin
        b = 8'(p * 7 + j);
        expectByte(b, (j == 5), $sformatf("wrap_p%0d_b%0d", p, j));
      end
    end
    chk("wrap_pktcount0", {27'd0, pktCount}, 32'd0);

    // ---------------- drop counter saturation ----------------
    for (int n = 0; n < 260; n++) begin
      sendByte(8'hF0, 1'b1, 1'b0);
    end
    chk("sat_dropcnt", {24'd0, dropCount}, 32'd255);
    chk("sat_dropped", {31'd0, pktDropped}, 32'd1);
    tick();
    chk("sat_dropped_clear", {31'd0, pktDropped}, 32'd0);
    chk("sat_rdvalid", {31'd0, rdValid}, 32'd0);

    // ---------------- reset mid-packet ----------------
    sendByte(8'h61, 1'b0, 1'b1);
    sendByte(8'h62, 1'b0, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_accept",   {31'd0, rxAcceptNewData}, 32'd0);
    chk("mid_rst_rdvalid",  {31'd0, rdValid}, 32'd0);
    chk("mid_rst_pktcount", {27'd0, pktCount}, 32'd0);
    chk("mid_rst_dropcnt",  {24'd0, dropCount}, 32'd0);
    chk("mid_rst_dropped",  {31'd0, pktDropped}, 32'd0);
    tick();
    chk("mid_rst_accept_hold", {31'd0, rxAcceptNewData}, 32'd0);
    @(negedge clk48);
    RST_N = 1'b1;
    tick();
    chk("mid_rst_accept_up", {31'd0, rxAcceptNewData}, 32'd1);
    sendByte(8'h71, 1'b0, 1'b1);
    sendByte(8'h72, 1'b0, 1'b1);
    sendByte(8'h73, 1'b1, 1'b1);
    chk("mid_rst_next_pktcount", {27'd0, pktCount}, 32'd1);
    expectByte(8'h71, 1'b0, "mid_rst_rd0");
    expectByte(8'h72, 1'b0, "mid_rst_rd1");
    expectByte(8'h73, 1'b1, "mid_rst_rd2");
    chk("mid_rst_empty", {31'd0, rdValid}, 32'd0);
    chk("mid_rst_dropcnt_after", {24'd0, dropCount}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
